// File: rtl/pixel_mem_responder.sv
// rtl/pixel_mem_responder.sv - data-side memory responder with RAM and RX/TX pixel byte FIFOs
//
// Purpose:
//   Serves processor word loads/stores into a local RAM and exposes two
//   memory-mapped byte FIFOs: RX (encrypted pixels in from the loader) and
//   TX (decrypted pixels out to the image sink), plus a status register.
//
// Ports:
//   clk, rst            - clock, asynchronous active-high reset
//   address             - processor byte address (bits [12:2] decoded)
//   writeData, WR       - store data and store strobe
//   MemtoReg            - load strobe (qualifies the RX pop)
//   readData            - combinational load data
//   in_data/in_valid/in_ready    - loader byte stream into RX FIFO
//   out_data/out_valid/out_ready - sink byte stream out of TX FIFO

module pixel_mem_responder #(
    parameter int RAM_WORDS  = 256,
    parameter int FIFO_DEPTH = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] address,
    input  logic [31:0] writeData,
    input  logic        WR,
    input  logic        MemtoReg,
    output logic [31:0] readData,
    input  logic [7:0]  in_data,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [7:0]  out_data,
    output logic        out_valid,
    input  logic        out_ready
);

    localparam int AW = $clog2(RAM_WORDS);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL_CNT  = CW'(FIFO_DEPTH);
    localparam logic [12:0]   RAM_BYTES = 13'(4 * RAM_WORDS);

    // ------------------------------------------------------------------
    // Address decode
    // ------------------------------------------------------------------
    logic [12:0]   w_addr;
    logic          w_is_ram;
    logic          w_is_rx;
    logic          w_is_tx;
    logic          w_is_status;
    logic [AW-1:0] w_ram_idx;
    logic          w_unused;

    assign w_addr      = address[12:0];
    assign w_is_ram    = (w_addr < RAM_BYTES);
    assign w_is_rx     = (w_addr[12:2] == 11'h400);
    assign w_is_tx     = (w_addr[12:2] == 11'h401);
    assign w_is_status = (w_addr[12:2] == 11'h402);
    assign w_ram_idx   = address[AW+1:2];
    assign w_unused    = ^{address[31:13], address[1:0]};

    // ------------------------------------------------------------------
    // Local RAM: full-word writes, contents not reset
    // ------------------------------------------------------------------
    logic [31:0] r_ram [RAM_WORDS];

    always_ff @(posedge clk) begin
        if (WR && w_is_ram) begin
            r_ram[w_ram_idx] <= writeData;
        end
    end

    // ------------------------------------------------------------------
    // FIFO state
    // ------------------------------------------------------------------
    logic [7:0]    r_rx_mem [FIFO_DEPTH];
    logic [7:0]    r_tx_mem [FIFO_DEPTH];
    logic [PW-1:0] r_rx_wptr;
    logic [PW-1:0] r_rx_rptr;
    logic [CW-1:0] r_rx_count;
    logic [PW-1:0] r_tx_wptr;
    logic [PW-1:0] r_tx_rptr;
    logic [CW-1:0] r_tx_count;
    logic          r_rx_underflow;
    logic          r_tx_overflow;

    logic w_rx_empty;
    logic w_tx_full;
    logic w_rx_push;
    logic w_rx_pop_req;
    logic w_rx_pop;
    logic w_tx_push_req;
    logic w_tx_push;
    logic w_tx_pop;
    logic w_uf_clr;
    logic w_of_clr;
    logic [7:0] w_rx_head;

    assign w_rx_empty = (r_rx_count == '0);
    assign w_tx_full  = (r_tx_count == FULL_CNT);

    // in_ready comes purely from registered count, so a same-edge
    // processor pop on a full RX FIFO cannot admit a loader byte.
    assign in_ready   = (r_rx_count != FULL_CNT);
    assign w_rx_push  = in_valid & in_ready;

    // A store takes priority over a load when both strobes are high.
    assign w_rx_pop_req = MemtoReg & ~WR & w_is_rx;
    assign w_rx_pop     = w_rx_pop_req & ~w_rx_empty;

    // Overflow is judged on the pre-edge count; a sink pop on the same
    // edge does not make room for the processor's byte.
    assign w_tx_push_req = WR & w_is_tx;
    assign w_tx_push     = w_tx_push_req & ~w_tx_full;

    assign out_valid = (r_tx_count != '0);
    assign w_tx_pop  = out_valid & out_ready;

    // Head bytes are masked when empty so stale storage never leaks out.
    assign out_data  = out_valid ? r_tx_mem[r_tx_rptr] : 8'h00;
    assign w_rx_head = w_rx_empty ? 8'h00 : r_rx_mem[r_rx_rptr];

    assign w_uf_clr = WR & w_is_status & writeData[24];
    assign w_of_clr = WR & w_is_status & writeData[25];

    // Byte storage needs no reset: validity is tracked by the counts.
    always_ff @(posedge clk) begin
        if (w_rx_push) begin
            r_rx_mem[r_rx_wptr] <= in_data;
        end
        if (w_tx_push) begin
            r_tx_mem[r_tx_wptr] <= writeData[7:0];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rx_wptr      <= '0;
            r_rx_rptr      <= '0;
            r_rx_count     <= '0;
            r_tx_wptr      <= '0;
            r_tx_rptr      <= '0;
            r_tx_count     <= '0;
            r_rx_underflow <= 1'b0;
            r_tx_overflow  <= 1'b0;
        end else begin
            if (w_rx_push) begin
                r_rx_wptr <= r_rx_wptr + 1'b1;
            end
            if (w_rx_pop) begin
                r_rx_rptr <= r_rx_rptr + 1'b1;
            end
            r_rx_count <= r_rx_count + CW'(w_rx_push) - CW'(w_rx_pop);

            if (w_tx_push) begin
                r_tx_wptr <= r_tx_wptr + 1'b1;
            end
            if (w_tx_pop) begin
                r_tx_rptr <= r_tx_rptr + 1'b1;
            end
            r_tx_count <= r_tx_count + CW'(w_tx_push) - CW'(w_tx_pop);

            // Set beats clear when both happen on the same edge.
            r_rx_underflow <= (w_rx_pop_req & w_rx_empty) | (r_rx_underflow & ~w_uf_clr);
            r_tx_overflow  <= (w_tx_push_req & w_tx_full) | (r_tx_overflow & ~w_of_clr);
        end
    end

    // ------------------------------------------------------------------
    // Status word and load data
    // ------------------------------------------------------------------
    logic [31:0] w_status;

    always_comb begin
        w_status        = '0;
        w_status[4:0]   = 5'(r_rx_count);
        w_status[12:8]  = 5'(r_tx_count);
        w_status[16]    = w_rx_empty;
        w_status[17]    = w_tx_full;
        w_status[24]    = r_rx_underflow;
        w_status[25]    = r_tx_overflow;
    end

    always_comb begin
        readData = '0;
        if (w_is_ram) begin
            readData = r_ram[w_ram_idx];
        end else if (w_is_rx) begin
            readData = {24'h0, w_rx_head};
        end else if (w_is_status) begin
            readData = w_status;
        end
    end

endmodule

// File: tb/tb_pixel_mem_responder.sv
// tb/tb_pixel_mem_responder.sv - directed self-checking bench for pixel_mem_responder
module tb_pixel_mem_responder;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] address;
    logic [31:0] writeData;
    logic        WR;
    logic        MemtoReg;
    logic [31:0] readData;
    logic [7:0]  in_data;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  out_data;
    logic        out_valid;
    logic        out_ready;

    int n_checks = 0;
    int n_pass   = 0;

    localparam logic [31:0] A_RX   = 32'h1000;
    localparam logic [31:0] A_TX   = 32'h1004;
    localparam logic [31:0] A_STAT = 32'h1008;

    pixel_mem_responder #(.RAM_WORDS(256), .FIFO_DEPTH(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .address   (address),
        .writeData (writeData),
        .WR        (WR),
        .MemtoReg  (MemtoReg),
        .readData  (readData),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; address = A_STAT; writeData = '0; WR = 1'b0; MemtoReg = 1'b0;
        in_data = '0; in_valid = 1'b0; out_ready = 1'b0;
        tick(); tick();
        rst = 1'b0;
        #1;
        check("reset_status", readData, 32'h0001_0000);
        check("reset_in_ready", 32'(in_ready), 32'd1);
        check("reset_out_valid", 32'(out_valid), 32'd0);
        check("reset_out_data", 32'(out_data), 32'd0);

        // RAM store then load
        address = 32'h0008; writeData = 32'hDEAD_BEEF; WR = 1'b1;
        tick();
        WR = 1'b0; #1;
        check("ram_load", readData, 32'hDEAD_BEEF);
        address = 32'h0800; #1;
        check("unmapped_load", readData, 32'h0);

        // RX: loader pushes three bytes, processor pops them
        in_valid = 1'b1;
        in_data = 8'h11; tick();
        in_data = 8'h22; tick();
        in_data = 8'h33; tick();
        in_valid = 1'b0;
        address = A_STAT; #1;
        check("rx_count3", readData, 32'h0000_0003);
        address = A_RX; MemtoReg = 1'b1; #1;
        check("rx_pop0", readData, 32'h11); tick();
        check("rx_pop1", readData, 32'h22); tick();
        check("rx_pop2", readData, 32'h33); tick();
        check("rx_pop_empty", readData, 32'h0); tick();
        MemtoReg = 1'b0; address = A_STAT; #1;
        check("rx_underflow", readData, 32'h0101_0000);
        writeData = 32'h0100_0000; WR = 1'b1; tick();
        WR = 1'b0; #1;
        check("uf_clear", readData, 32'h0001_0000);

        // TX: 17 pushes into a 16-deep FIFO with the sink stalled
        address = A_TX; WR = 1'b1;
        for (int i = 0; i < 17; i++) begin
            writeData = 32'hA0 + 32'(i);
            tick();
        end
        WR = 1'b0; address = A_STAT; #1;
        check("tx_full_status", readData, 32'h0203_1000);
        check("tx_full_in_ready", 32'(in_ready), 32'd1);
        check("tx_out_valid", 32'(out_valid), 32'd1);
        address = A_TX; #1;
        check("tx_data_read0", readData, 32'h0);
        out_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            check($sformatf("tx_drain%0d", i), 32'(out_data), 32'hA0 + 32'(i));
            tick();
        end
        out_ready = 1'b0;
        check("tx_drained", 32'(out_valid), 32'd0);
        address = A_STAT; writeData = 32'h0200_0000; WR = 1'b1; tick();
        WR = 1'b0; #1;
        check("of_clear", readData, 32'h0001_0000);
        address = 32'h0008; #1;
        check("ram_retained", readData, 32'hDEAD_BEEF);

        // RX full, processor pop and loader push on the same edge
        in_valid = 1'b1;
        for (int i = 0; i < 16; i++) begin
            in_data = 8'h40 + 8'(i);
            tick();
        end
        in_data = 8'h77;
        address = A_STAT; #1;
        check("rx_full_count", readData, 32'h0000_0010);
        check("rx_full_in_ready", 32'(in_ready), 32'd0);
        address = A_RX; MemtoReg = 1'b1; #1;
        check("rx_full_head", readData, 32'h40);
        tick();
        MemtoReg = 1'b0; address = A_STAT; #1;
        check("rx_pop_no_push", readData, 32'h0000_000F);
        check("rx_ready_again", 32'(in_ready), 32'd1);
        tick();
        in_valid = 1'b0; #1;
        check("rx_refill", readData, 32'h0000_0010);
        address = A_RX; MemtoReg = 1'b1;
        for (int i = 1; i < 17; i++) begin
            #1;
            check($sformatf("rx_order%0d", i), readData, (i == 16) ? 32'h77 : 32'h40 + 32'(i));
            tick();
        end
        MemtoReg = 1'b0;

        // Async reset with both FIFOs half full and a sticky flag set
        address = A_RX; MemtoReg = 1'b1; tick(); MemtoReg = 1'b0;
        in_valid = 1'b1; address = A_TX; WR = 1'b1;
        for (int i = 0; i < 8; i++) begin
            in_data = 8'(i); writeData = 32'(i);
            tick();
        end
        in_valid = 1'b0; WR = 1'b0; address = A_STAT; #1;
        check("half_full_status", readData, 32'h0100_0808);
        #2;
        rst = 1'b1;
        #1;
        check("async_out_valid", 32'(out_valid), 32'd0);
        check("async_status", readData, 32'h0001_0000);
        check("async_in_ready", 32'(in_ready), 32'd1);
        tick();
        rst = 1'b0; #1;
        check("post_reset_status", readData, 32'h0001_0000);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/pixel_mem_responder.md
# pixel_mem_responder

Data-side responder for the processor's memory port, with an image-pixel streaming path. It serves word loads and stores into a local RAM. It also exposes two memory-mapped byte FIFOs: one for encrypted pixels arriving from the loader (RX) and one for decrypted pixels leaving toward the image sink (TX). It sits between the processor's `address`/`writeData`/`WR`/`MemtoReg` outputs and its `readData` input.

## Interface
- `RAM_WORDS`, 256: local RAM depth in 32-bit words; power of two, ≤ 1024.
- `FIFO_DEPTH`, 16: depth of each byte FIFO; power of two, 2..16.
- `clk`  in  1: single clock; all state updates on its rising edge.
- `rst`  in  1: asynchronous, active-high reset.
- `address`  in  32: processor byte address; bits [1:0] ignored.
- `writeData`  in  32: store data.
- `WR`  in  1: store strobe, sampled at the rising edge.
- `MemtoReg`  in  1: load strobe; qualifies the RX pop side effect.
- `readData`  out  32: load data, combinational from `address` and current state.
- `in_data`  in  8: encrypted pixel byte from the loader.
- `in_valid`  in  1: `in_data` is valid.
- `in_ready`  out  1: RX FIFO can accept a byte.
- `out_data`  out  8: decrypted pixel byte at the head of the TX FIFO.
- `out_valid`  out  1: TX FIFO is non-empty.
- `out_ready`  in  1: sink accepts `out_data`.

## Operation
- Address map (decoded on `address[12:0]`; upper bits ignored):
  - 0x0000 to 4*RAM_WORDS-1: RAM; word index = `address[log2(RAM_WORDS)+1:2]`.
  - 0x1000 RX_DATA: read returns `{24'b0, rx head}`; writes ignored.
  - 0x1004 TX_DATA: write pushes `writeData[7:0]`; reads return 0.
  - 0x1008 STATUS: read-only counts, write-1-to-clear flags.
    - [4:0] rx_count
    - [12:8] tx_count
    - [16] rx_empty
    - [17] tx_full
    - [24] rx_underflow (sticky)
    - [25] tx_overflow (sticky)
    - all other bits 0.
  - Any other address: reads return 0; writes have no effect.
- RAM store: on an edge with `WR`=1 in the RAM range, the word is written in full (no byte enables). RAM contents are not reset.
- RAM load: `readData` shows the addressed word combinationally. A store followed by a load of the same address reads the new value on the next cycle.
- RX pop: on an edge with `MemtoReg`=1, `WR`=0 and address RX_DATA, the head is consumed.
  - If the RX FIFO is empty: `readData`=0, pointers are unchanged, rx_underflow is set.
- TX push: on an edge with `WR`=1 and address TX_DATA, the byte is pushed.
  - If tx_count=FIFO_DEPTH before the edge: the byte is dropped and tx_overflow is set, even if `out_ready` pops in the same cycle.
- Flag clear: a `WR` to STATUS with `writeData[24]`/`[25]`=1 clears the corresponding flag. If a set event and a clear occur on the same edge, the set wins.
- `WR` and `MemtoReg` both high: treated as a store only; no RX pop.
- Stream side:
  - `in_ready` = (rx_count < FIFO_DEPTH), taken from registered state.
  - A push occurs on an edge with `in_valid & in_ready`.
  - `out_valid` = (tx_count != 0); `out_data` = TX head.
  - A pop occurs on an edge with `out_valid & out_ready`.
- Simultaneous push and pop on the same FIFO: both take effect and the count is unchanged. When the FIFO is full, a same-edge processor pop does not enable a loader push, because `in_ready` was already low.
- Pointers wrap modulo FIFO_DEPTH. Counts are FIFO_DEPTH-bit-safe, range 0..FIFO_DEPTH.

## Timing
- Reset (asynchronous, immediate):
  - Pointers, counts and sticky flags = 0.
  - `in_ready`=1, `out_valid`=0, `out_data`=0.
  - `readData` for STATUS = 0x0001_0000.
- Reset asserted mid-transfer: FIFOs are flushed instantly. The in-flight byte is lost and no flag is set.
- Load latency: 0 cycles (combinational), consistent with the single-cycle core. Side effects (pop, push, flag updates) commit at the rising edge ending the access.
- RX byte latency: a byte pushed at edge N is visible at RX_DATA and in rx_count after edge N.
- TX byte latency: a byte pushed at edge N gives `out_valid`=1 after edge N.
- Throughput: one byte per cycle per FIFO, in each direction.

## Test plan
- Reset with `WR`=0, `MemtoReg`=0; read STATUS -> `readData`=0x0001_0000, `in_ready`=1, `out_valid`=0.
- Store 0xDEADBEEF to 0x0008, then load 0x0008 -> 0xDEADBEEF. Load 0x000C (unwritten word) -> any value. Load 0x0800 -> 0.
- Loader pushes 0x11, 0x22, 0x33. Three loads of RX_DATA -> 0x11, 0x22, 0x33 in order. A fourth load -> 0, with STATUS[24]=1. Write 0x0100_0000 to STATUS -> STATUS[24]=0.
- With `out_ready`=0, push 17 bytes to TX_DATA (FIFO_DEPTH=16) -> tx_count=16, `in_ready` unaffected, STATUS[25]=1, byte 17 absent. Raise `out_ready` -> 16 bytes drained in order, then `out_valid`=0.
- RX full (16 entries) with `in_valid`=1 and a processor pop on the same edge -> count 15, no push on that edge. The push occurs on the next edge -> count 16.
- Assert `rst` asynchronously mid-cycle with both FIFOs half full -> `out_valid`=0 and STATUS=0x0001_0000 immediately. Sticky flags are cleared.
